// File: rtl/vector_mem_sequencer_if.sv
// Port bundle for the vector memory sequencer: request, result and data-memory signals.
// Latency: none, wires only.
// Backpressure: none; start is a strobe that the sequencer accepts only while idle.
interface vector_mem_sequencer_if #(
  parameter int LANES         = 8,
  parameter int DATA_WIDTH    = 64,
  parameter int ADDRESS_WIDTH = 19
);
  localparam int COUNT_WIDTH = $clog2(LANES + 1);

  // request side
  logic                          start;
  logic                          op_store;
  logic [ADDRESS_WIDTH-1:0]      base_addr;
  logic [ADDRESS_WIDTH-1:0]      stride;
  logic [COUNT_WIDTH-1:0]        count;
  logic [LANES*DATA_WIDTH-1:0]   store_vector;
  logic [LANES*DATA_WIDTH-1:0]   load_vector;
  logic                          busy;
  logic                          done;
  logic                          err;

  // data memory side
  logic [ADDRESS_WIDTH-1:0]      mem_read_address;
  logic [DATA_WIDTH-1:0]         mem_read_data;
  logic [ADDRESS_WIDTH-1:0]      mem_write_address;
  logic [DATA_WIDTH-1:0]         mem_write_data;
  logic                          mem_write_enable;

  // sequencer view: it initiates the memory accesses
  modport master (
    input  start, op_store, base_addr, stride, count, store_vector, mem_read_data,
    output load_vector, busy, done, err,
           mem_read_address, mem_write_address, mem_write_data, mem_write_enable
  );

  // environment view: requester plus data memory
  modport slave (
    output start, op_store, base_addr, stride, count, store_vector, mem_read_data,
    input  load_vector, busy, done, err,
           mem_read_address, mem_write_address, mem_write_data, mem_write_enable
  );
endinterface

// File: rtl/vector_mem_sequencer.sv
// Splits one strided vector load/store into single-word memory accesses, one lane per cycle.
// Latency: start accepted at edge N -> done pulses in cycle N+min(count,LANES)+1.
// Backpressure: none; start is ignored unless IDLE, requester re-asserts after done.
// Optional: VECTOR_MEM_SEQUENCER_ADDR_CHECK_EN enables the MEM_SIZE range check and err.
module vector_mem_sequencer #(
  parameter int LANES         = 8,
  parameter int DATA_WIDTH    = 64,
  parameter int ADDRESS_WIDTH = 19,
  parameter int MEM_SIZE      = 2000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  vector_mem_sequencer_if.master bus
);
  localparam int CW = $clog2(LANES + 1);
  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                               state_q, state_d;
  logic                                 op_store_q;
  logic [ADDRESS_WIDTH-1:0]             stride_q;
  logic [ADDRESS_WIDTH-1:0]             addr_q;
  logic [CW-1:0]                        idx_q;
  logic [CW-1:0]                        eff_cnt_q;
  logic [LANES-1:0][DATA_WIDTH-1:0]     store_lanes_q;
  logic [LANES-1:0][DATA_WIDTH-1:0]     load_lanes_q;

  logic [CW-1:0]                        eff_count;
  logic [IW-1:0]                        lane_sel;
  logic                                 accept;
  logic                                 last_elem;
  logic                                 in_range;

  // requests longer than the vector are clipped to LANES elements
  assign eff_count = (bus.count > CW'(LANES)) ? CW'(LANES) : bus.count;
  assign lane_sel  = idx_q[IW-1:0];
  assign accept    = (state_q == IDLE) && bus.start;
  assign last_elem = (idx_q == eff_cnt_q - CW'(1));

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = (eff_count == '0) ? DONE : ACCESS;
      ACCESS:  if (last_elem) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // latch the request at accept, then walk index and address one element per cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_store_q    <= 1'b0;
      stride_q      <= '0;
      addr_q        <= '0;
      idx_q         <= '0;
      eff_cnt_q     <= '0;
      store_lanes_q <= '0;
    end else if (accept) begin
      op_store_q    <= bus.op_store;
      stride_q      <= bus.stride;
      addr_q        <= bus.base_addr;
      idx_q         <= '0;
      eff_cnt_q     <= eff_count;
      store_lanes_q <= bus.store_vector;
    end else if (state_q == ACCESS) begin
      idx_q  <= idx_q + CW'(1);
      // address arithmetic wraps modulo 2^ADDRESS_WIDTH by construction
      addr_q <= addr_q + stride_q;
    end
  end

  // load assembly: cleared at a load accept, one lane filled per access cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_lanes_q <= '0;
    end else if (accept && !bus.op_store) begin
      load_lanes_q <= '0;
    end else if ((state_q == ACCESS) && !op_store_q) begin
      load_lanes_q[lane_sel] <= in_range ? bus.mem_read_data : '0;
    end
  end

`ifdef VECTOR_MEM_SEQUENCER_ADDR_CHECK_EN
  localparam logic [ADDRESS_WIDTH:0] MEM_LIMIT = (ADDRESS_WIDTH + 1)'(MEM_SIZE);
  logic err_q;

  assign in_range = ({1'b0, addr_q} < MEM_LIMIT);

  // sticky range error, cleared by the next accepted request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                            err_q <= 1'b0;
    else if (accept)                         err_q <= 1'b0;
    else if ((state_q == ACCESS) && !in_range) err_q <= 1'b1;
  end

  assign bus.err = err_q;
`else
  // no range check: every element goes to memory unmodified
  logic unused_mem_size;
  assign unused_mem_size = (MEM_SIZE == 0);
  assign in_range        = 1'b1;
  assign bus.err         = 1'b0;
`endif

  assign bus.busy              = (state_q == ACCESS);
  assign bus.done              = (state_q == DONE);
  assign bus.load_vector       = load_lanes_q;
  assign bus.mem_read_address  = addr_q;
  assign bus.mem_write_address = addr_q;
  assign bus.mem_write_data    = (state_q == ACCESS) ? store_lanes_q[lane_sel] : '0;
  // state-derived so an asynchronous reset removes the strobe immediately
  assign bus.mem_write_enable  = (state_q == ACCESS) && op_store_q && in_range;

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Self-checking bench for vector_mem_sequencer: directed cases plus random requests
// against a reference model of strided gather/scatter over a sparse word memory.
// Defining VECTOR_MEM_SEQUENCER_ADDR_CHECK_EN also models the range check.
`timescale 1ns/1ps
module tb_vector_mem_sequencer;
  localparam int LANES    = 8;
  localparam int DW       = 64;
  localparam int AW       = 19;
  localparam int MEM_SIZE = 2000;
  localparam int CW       = $clog2(LANES + 1);
  localparam int VW       = LANES * DW;
`ifdef VECTOR_MEM_SEQUENCER_ADDR_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  vector_mem_sequencer_if #(.LANES(LANES), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  vector_mem_sequencer #(
    .LANES(LANES), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MEM_SIZE(MEM_SIZE)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // memory written by the DUT, and the memory the model expects
  logic [DW-1:0] mem     [int];
  logic [DW-1:0] ref_mem [int];
  int            mem_gen = 0;
  logic [VW-1:0] last_load;

  function automatic logic [DW-1:0] fill(input int a);
    return {32'hC0DE_5EED, a};
  endfunction

  function automatic logic [DW-1:0] rd_mem(input int a);
    return mem.exists(a) ? mem[a] : fill(a);
  endfunction

  function automatic logic [DW-1:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : fill(a);
  endfunction

  // combinational read port
  always @(bus.mem_read_address, mem_gen)
    bus.mem_read_data = rd_mem(int'(bus.mem_read_address));

  // write port: sample the strobe mid-cycle, commit on the rising edge
  logic          pend_we;
  logic [AW-1:0] pend_a;
  logic [DW-1:0] pend_d;
  always @(negedge clk) begin
    pend_we = bus.mem_write_enable;
    pend_a  = bus.mem_write_address;
    pend_d  = bus.mem_write_data;
  end
  always @(posedge clk) begin
    if (pend_we === 1'b1 && reset_n === 1'b1) begin
      mem[int'(pend_a)] = pend_d;
      mem_gen++;
    end
  end

  task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // one request: model it, drive it, watch it to completion, compare everything
  task automatic run_op(input bit st, input logic [AW-1:0] b, input logic [AW-1:0] s,
                        input logic [CW-1:0] c, input logic [VW-1:0] sv, input bit scramble);
    int            n;
    int            exp_we;
    bit            exp_err;
    logic [AW-1:0] ea [$];
    bit            eoob [$];
    logic [AW-1:0] got_a [$];
    int            busy_n, we_n, done_cyc;
    logic [AW-1:0] a;

    n       = (int'(c) > LANES) ? LANES : int'(c);
    exp_we  = 0;
    exp_err = 1'b0;
    for (int i = 0; i < n; i++) begin
      a = AW'(longint'(b) + longint'(i) * longint'(s));
      ea.push_back(a);
      eoob.push_back(RANGE_CHECK && (int'(a) >= MEM_SIZE));
      if (eoob[i]) exp_err = 1'b1;
      else if (st) exp_we++;
    end
    if (!st) begin
      last_load = '0;
      for (int i = 0; i < n; i++)
        last_load[i*DW +: DW] = eoob[i] ? '0 : ref_rd(int'(ea[i]));
    end else begin
      for (int i = 0; i < n; i++)
        if (!eoob[i]) ref_mem[int'(ea[i])] = sv[i*DW +: DW];
    end

    @(negedge clk);
    bus.start        = 1'b1;
    bus.op_store     = st;
    bus.base_addr    = b;
    bus.stride       = s;
    bus.count        = c;
    bus.store_vector = sv;
    @(negedge clk);
    bus.start = 1'b0;
    if (scramble) begin
      bus.start        = 1'b1;
      bus.op_store     = ~st;
      bus.base_addr    = AW'($urandom);
      bus.stride       = AW'($urandom);
      bus.count        = CW'($urandom_range(0, 15));
      bus.store_vector = rand_vec();
    end

    busy_n = 0; we_n = 0; done_cyc = 0;
    for (int k = 1; k <= 40; k++) begin
      if (bus.busy === 1'b1) begin
        busy_n++;
        got_a.push_back(bus.mem_read_address);
        chk("wr_addr_eq_rd_addr", bus.mem_write_address, bus.mem_read_address);
      end
      if (bus.mem_write_enable === 1'b1) we_n++;
      if (bus.done === 1'b1) begin
        done_cyc = k;
        break;
      end
      @(negedge clk);
    end

    chk("done_latency", done_cyc, n + 1);
    chk("busy_cycles", busy_n, n);
    chk("we_cycles", we_n, exp_we);
    for (int i = 0; i < n; i++)
      chk("addr_seq", (i < got_a.size()) ? got_a[i] : 'x, ea[i]);
    chk("err", bus.err, exp_err);
    chk("load_vector", bus.load_vector, last_load);
    if (st) begin
      for (int i = 0; i < n; i++)
        for (int d = -1; d <= 1; d++) begin
          a = AW'(int'(ea[i]) + d);
          chk("mem_word", rd_mem(int'(a)), ref_rd(int'(a)));
        end
    end

    @(negedge clk);
    bus.start = 1'b0;
    chk("idle_busy", bus.busy, 1'b0);
    chk("idle_done", bus.done, 1'b0);
  endtask

  task automatic reset_mid_store();
    logic [VW-1:0] sv;
    int            wes;
    sv = rand_vec();
    @(negedge clk);
    bus.start = 1'b1; bus.op_store = 1'b1; bus.base_addr = AW'(500);
    bus.stride = AW'(1); bus.count = CW'(8); bus.store_vector = sv;
    @(negedge clk);
    bus.start = 1'b0;
    wes = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.mem_write_enable === 1'b1) wes++;
      if (wes == 3) break;
      @(negedge clk);
    end
    chk("rst_seen_3_writes", wes, 3);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_we_drop", bus.mem_write_enable, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_load_vector", bus.load_vector, '0);
    for (int i = 0; i < 3; i++) ref_mem[500 + i] = sv[i*DW +: DW];
    last_load = '0;
    @(negedge clk);
    for (int a = 499; a <= 509; a++) chk("rst_mem_word", rd_mem(a), ref_rd(a));
    reset_n = 1'b1;
    run_op(1'b0, AW'(499), AW'(1), CW'(8), '0, 1'b0);
  endtask

  initial begin
    logic [VW-1:0] sv;
    reset_n          = 1'b0;
    bus.start        = 1'b0;
    bus.op_store     = 1'b0;
    bus.base_addr    = '0;
    bus.stride       = '0;
    bus.count        = '0;
    bus.store_vector = '0;
    last_load        = '0;
    #12;
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_done", bus.done, 1'b0);
    chk("reset_err", bus.err, 1'b0);
    chk("reset_we", bus.mem_write_enable, 1'b0);
    chk("reset_load_vector", bus.load_vector, '0);
    chk("reset_rd_addr", bus.mem_read_address, '0);
    chk("reset_wr_addr", bus.mem_write_address, '0);
    chk("reset_wr_data", bus.mem_write_data, '0);
    @(negedge clk);
    reset_n = 1'b1;

    // contiguous load of prepared words
    for (int i = 0; i < 8; i++) begin
      mem[16 + i]     = 64'(8'hA0 + i);
      ref_mem[16 + i] = 64'(8'hA0 + i);
    end
    mem_gen++;
    run_op(1'b0, AW'(16), AW'(1), CW'(8), '0, 1'b0);

    // strided store of four lanes
    sv = '0;
    sv[0*DW +: DW] = 64'h11; sv[1*DW +: DW] = 64'h22;
    sv[2*DW +: DW] = 64'h33; sv[3*DW +: DW] = 64'h44;
    run_op(1'b1, AW'(100), AW'(3), CW'(4), sv, 1'b0);

    // empty request, then an over-long one clipped to LANES
    run_op(1'b0, AW'(40), AW'(2), CW'(0), '0, 1'b0);
    run_op(1'b0, AW'(100), AW'(1), CW'(12), '0, 1'b1);

    // address wrap at the top of the space
    run_op(1'b0, AW'(19'h7FFFE), AW'(1), CW'(4), '0, 1'b0);

    // straddling the implemented range boundary
    run_op(1'b0, AW'(1998), AW'(1), CW'(4), '0, 1'b0);
    run_op(1'b1, AW'(1997), AW'(2), CW'(3), rand_vec(), 1'b0);

    reset_mid_store();

    for (int t = 0; t < 40; t++) begin
      logic [AW-1:0] b, s;
      b = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 2100)) : AW'($urandom);
      s = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 5));
      run_op(1'($urandom_range(0, 1)), b, s, CW'($urandom_range(0, 15)), rand_vec(),
             1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
